id_ex_skid_reg: RTL



---
 rtl/id_ex_skid_reg_pkg.sv | 32 +++
 rtl/id_ex_skid_reg_entry.sv | 40 ++++
 rtl/id_ex_skid_reg.sv | 138 +++++++++++++
 3 files changed

// File: rtl/id_ex_skid_reg_pkg.sv
// Shared widths, opcode constants and the instruction bundle for the ID/EX boundary.
package id_ex_skid_reg_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned RD_W     = 3;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned BUNDLE_W = OP_W + 2 * DATA_W + RD_W + 1;
  localparam int unsigned STALL_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;

  // One decoded instruction as it crosses into EX.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [RD_W-1:0]   rd;
    logic              wb;
  } instr_t;

  // Occupancy encoded as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } state_t;

endpackage

// File: rtl/id_ex_skid_reg_entry.sv
// One bundle register with load enable and its own valid bit.
module id_ex_skid_reg_entry
  import id_ex_skid_reg_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   valid_in,
  input  instr_t data_in,
  output logic   valid_out,
  output instr_t data_out
);

  logic   valid_d, valid_q;
  instr_t data_d, data_q;

  // Data only changes on a load; valid follows the controller's decision.
  always_comb begin
    valid_d = valid_in;
    data_d  = data_q;
    if (load) begin
      data_d = data_in;
    end
  end

  // Entry state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a 2-entry skid buffer and flush.
// Optional macro ID_EX_STALL_CNT_EN adds a saturating stall_cnt output.
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  logic   main_valid_q, skid_valid_q;
  logic   main_valid_d, skid_valid_d;
  logic   main_load, skid_load, main_from_skid;
  logic   accept, drain;
  instr_t in_bundle, main_data, skid_data, main_in;
  state_t state;

  assign in_bundle = '{op: in_op, a: in_a, b: in_b, rd: in_rd, wb: in_wb};
  assign accept    = in_valid && !skid_valid_q;
  assign drain     = main_valid_q && out_ready;
  assign state     = state_t'({main_valid_q, skid_valid_q});
  assign main_in   = main_from_skid ? skid_data : in_bundle;

  // Next occupancy and load enables; flush overrides everything.
  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_load    = 1'b1;
          main_valid_d = 1'b1;
        end
      end
      ST_FULL1: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (drain) begin
          main_valid_d = 1'b0;
        end else if (accept) begin
          skid_load    = 1'b1;
          skid_valid_d = 1'b1;
        end
      end
      ST_FULL2: begin
        if (drain) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_valid_d   = 1'b0;
        end
      end
      default: begin
        // Skid without main is unreachable; recover to empty.
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_load    = 1'b0;
      skid_load    = 1'b0;
    end
  end

  id_ex_skid_reg_entry u_main (
    .clock     (clock),
    .reset     (reset),
    .load      (main_load),
    .valid_in  (main_valid_d),
    .data_in   (main_in),
    .valid_out (main_valid_q),
    .data_out  (main_data)
  );

  id_ex_skid_reg_entry u_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (skid_load),
    .valid_in  (skid_valid_d),
    .data_in   (in_bundle),
    .valid_out (skid_valid_q),
    .data_out  (skid_data)
  );

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_op    = main_data.op;
  assign out_a     = main_data.a;
  assign out_b     = main_data.b;
  assign out_rd    = main_data.rd;
  assign out_wb    = main_data.wb;

`ifdef ID_EX_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt_d, stall_cnt_q;

  // Count cycles where EX holds off a valid entry; saturate, clear on reset only.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
